// File: rtl/bin_record_packer.sv
// bin_record_packer
// Collects one header plus up to MAX_FLITS payload flits, then streams the
// record as 64-bit words: generic header (type, data start, data end),
// type-specific header words, then one (data, keep, last) triple per flit.
// ds/de are byte addresses in the output file, so a reader can seek straight
// to the payload of any record.
module bin_record_packer #(
    parameter logic [63:0] BASE_ADDR = 64'h40,
    parameter int          MAX_FLITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [7:0]  hdr_type,
    input  logic [47:0] mac_src,
    input  logic [47:0] mac_dst,
    input  logic [15:0] dst,
    input  logic [15:0] dst_rank,
    input  logic [7:0]  src_rank,
    input  logic [7:0]  packet_type,
    input  logic [31:0] size,
    input  logic [7:0]  tag,
    input  logic [31:0] ip_dst,
    input  logic [31:0] ip_src,
    input  logic        last,
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [63:0] pay_data,
    input  logic [7:0]  pay_keep,
    input  logic        pay_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic [31:0] rec_count,
    output logic        err_trunc
);
    localparam int CNT_W = $clog2(MAX_FLITS + 1);
    localparam int IDX_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
    localparam logic [7:0] TYPE_ETH = 8'd1;
    localparam logic [7:0] TYPE_MPI = 8'd2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DROP,
        EMIT_GEN,
        EMIT_EXT,
        EMIT_PAY
    } state_t;

    state_t state, state_next;

    // Captured header fields
    logic [7:0]  type_r;
    logic [47:0] mac_src_r;
    logic [47:0] mac_dst_r;
    logic [15:0] dst_r;
    logic [15:0] dst_rank_r;
    logic [7:0]  src_rank_r;
    logic [7:0]  packet_type_r;
    logic [31:0] size_r;
    logic [7:0]  tag_r;
    logic [31:0] ip_dst_r;
    logic [31:0] ip_src_r;
    logic        last_r;
    logic [3:0]  ext_words;

    // Payload flit buffer
    logic [63:0] buf_data [MAX_FLITS];
    logic [7:0]  buf_keep [MAX_FLITS];
    logic        buf_last [MAX_FLITS];
    logic [CNT_W-1:0] count;

    // Emission bookkeeping: sub walks words inside a state, fidx walks flits
    logic [63:0]      wp;
    logic [63:0]      ds;
    logic [63:0]      de;
    logic [3:0]       sub;
    logic [CNT_W-1:0] fidx;
    logic             gen_done;

    logic        hdr_fire;
    logic        pay_fire;
    logic        out_fire;
    logic        out_space;
    logic        gen_valid;
    logic        load;
    logic [63:0] cur_word;
    logic        cur_last;
    logic        cur_end;

    assign hdr_fire  = hdr_valid & hdr_ready;
    assign pay_fire  = pay_valid & pay_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_space = ~out_valid | out_ready;

    // wp and count stay frozen from the last flit until the record's final
    // handshake, so these offsets are constant for the whole emission.
    assign ds = wp + 64'(8 * (32'(ext_words) + 32'd3));
    assign de = ds + 64'(count) * 64'd24;

    // Next-state, handshake readiness and current output word selection
    always_comb begin
        state_next = state;
        hdr_ready  = 1'b0;
        pay_ready  = 1'b0;
        gen_valid  = 1'b0;
        load       = 1'b0;
        cur_word   = 64'd0;
        cur_last   = 1'b0;
        cur_end    = 1'b0;
        case (state)
            IDLE: begin
                hdr_ready = 1'b1;
                if (hdr_valid) state_next = COLLECT;
            end
            COLLECT: begin
                pay_ready = (count < CNT_W'(MAX_FLITS));
                if (pay_valid && pay_ready) begin
                    if (pay_last)
                        state_next = EMIT_GEN;
                    else if (count == CNT_W'(MAX_FLITS - 1))
                        state_next = DROP;
                end
            end
            DROP: begin
                pay_ready = 1'b1;
                if (pay_valid && pay_last) state_next = EMIT_GEN;
            end
            EMIT_GEN: begin
                gen_valid = ~gen_done;
                load      = gen_valid & out_space;
                case (sub)
                    4'd0:    cur_word = {56'd0, type_r};
                    4'd1:    cur_word = ds;
                    default: cur_word = de;
                endcase
                cur_end  = (sub == 4'd2);
                cur_last = cur_end && (ext_words == 4'd0) && (count == '0);
                if (load && cur_end && !cur_last)
                    state_next = (ext_words != 4'd0) ? EMIT_EXT : EMIT_PAY;
            end
            EMIT_EXT: begin
                gen_valid = ~gen_done;
                load      = gen_valid & out_space;
                if (type_r == TYPE_ETH) begin
                    case (sub)
                        4'd0:    cur_word = {16'd0, mac_src_r};
                        4'd1:    cur_word = {16'd0, mac_dst_r};
                        default: cur_word = {48'd0, dst_r};
                    endcase
                end else begin
                    case (sub)
                        4'd0:    cur_word = {48'd0, dst_rank_r};
                        4'd1:    cur_word = {56'd0, src_rank_r};
                        4'd2:    cur_word = {56'd0, packet_type_r};
                        4'd3:    cur_word = {32'd0, size_r};
                        4'd4:    cur_word = {56'd0, tag_r};
                        4'd5:    cur_word = {16'd0, mac_dst_r};
                        4'd6:    cur_word = {16'd0, mac_src_r};
                        4'd7:    cur_word = {32'd0, ip_dst_r};
                        4'd8:    cur_word = {32'd0, ip_src_r};
                        default: cur_word = {63'd0, last_r};
                    endcase
                end
                cur_end  = (sub == ext_words - 4'd1);
                cur_last = cur_end && (count == '0);
                if (load && cur_end && !cur_last) state_next = EMIT_PAY;
            end
            EMIT_PAY: begin
                gen_valid = ~gen_done;
                load      = gen_valid & out_space;
                case (sub)
                    4'd0:    cur_word = buf_data[fidx[IDX_W-1:0]];
                    4'd1:    cur_word = {56'd0, buf_keep[fidx[IDX_W-1:0]]};
                    default: cur_word = {63'd0, buf_last[fidx[IDX_W-1:0]]};
                endcase
                cur_end  = (sub == 4'd2);
                cur_last = cur_end && (fidx == count - CNT_W'(1));
            end
            default: state_next = IDLE;
        endcase
        // The final handshake closes the record regardless of which emit
        // state produced the last word.
        if (out_fire && out_last) state_next = IDLE;
    end

    // Control state, counters, output register and record bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            wp        <= BASE_ADDR;
            sub       <= 4'd0;
            fidx      <= '0;
            gen_done  <= 1'b0;
            ext_words <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= 64'd0;
            out_last  <= 1'b0;
            rec_count <= 32'd0;
            err_trunc <= 1'b0;
        end else begin
            state     <= state_next;
            err_trunc <= 1'b0;
            if (hdr_fire) begin
                case (hdr_type)
                    TYPE_ETH: ext_words <= 4'd3;
                    TYPE_MPI: ext_words <= 4'd10;
                    default:  ext_words <= 4'd0;
                endcase
            end
            if (state == COLLECT && pay_fire) begin
                count <= count + CNT_W'(1);
                if (!pay_last && count == CNT_W'(MAX_FLITS - 1))
                    err_trunc <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= cur_word;
                out_last  <= cur_last;
                sub       <= cur_end ? 4'd0 : sub + 4'd1;
                if (state == EMIT_PAY && cur_end) fidx <= fidx + CNT_W'(1);
                if (cur_last) gen_done <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (out_fire && out_last) begin
                wp        <= de;
                count     <= '0;
                sub       <= 4'd0;
                fidx      <= '0;
                gen_done  <= 1'b0;
                rec_count <= rec_count + 32'd1;
            end
        end
    end

    // Header field capture on the accepting handshake
    always_ff @(posedge clk) begin
        if (hdr_fire) begin
            type_r        <= hdr_type;
            mac_src_r     <= mac_src;
            mac_dst_r     <= mac_dst;
            dst_r         <= dst;
            dst_rank_r    <= dst_rank;
            src_rank_r    <= src_rank;
            packet_type_r <= packet_type;
            size_r        <= size;
            tag_r         <= tag;
            ip_dst_r      <= ip_dst;
            ip_src_r      <= ip_src;
            last_r        <= last;
        end
    end

    // Payload buffer write; the flit that fills the buffer is marked last so
    // a truncated record still terminates cleanly for the reader.
    always_ff @(posedge clk) begin
        if (state == COLLECT && pay_fire) begin
            buf_data[count[IDX_W-1:0]] <= pay_data;
            buf_keep[count[IDX_W-1:0]] <= pay_keep;
            buf_last[count[IDX_W-1:0]] <= pay_last | (count == CNT_W'(MAX_FLITS - 1));
        end
    end

endmodule
